// File: rtl/rv32_pkg.sv
// Shared RV32 fetch-stage constants, also used by the PC+4 adder, the PC mux and
// instruction memory.
package rv32_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;

endpackage : rv32_pkg

// File: rtl/program_counter.sv
// Architectural PC register for the fetch stage. It stores the next-PC value each
// edge and performs no selection or arithmetic.
module program_counter #(
    parameter int                          XLEN         = rv32_pkg::XLEN,
    parameter logic [rv32_pkg::XLEN-1:0]   RESET_VECTOR = rv32_pkg::RESET_VECTOR
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] PC_in,
    output logic [XLEN-1:0] PC_out
);

    // Stalls are handled upstream by feeding PC_out back to PC_in, so the
    // register loads on every edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            PC_out <= RESET_VECTOR[XLEN-1:0];
        end else begin
            PC_out <= PC_in;
        end
    end

endmodule : program_counter

// File: tb/tb_program_counter.sv
// Directed self-checking bench for program_counter: reset, pass-through, one-cycle
// latency, synchronous reset and full-width values.
module tb_program_counter;

    localparam int XLEN = 32;

    logic            clk;
    logic            reset;
    logic [XLEN-1:0] PC_in;
    logic [XLEN-1:0] PC_out;

    int checkCount;
    int passCount;
    logic [XLEN-1:0] prevExpected;

    program_counter #(
        .XLEN(XLEN),
        .RESET_VECTOR(32'h0000_0000)
    ) dut (
        .clk(clk),
        .reset(reset),
        .PC_in(PC_in),
        .PC_out(PC_out)
    );

    // The first rising edge falls at 5 ns, with a 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [XLEN-1:0] observed,
                               input logic [XLEN-1:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Drives inputs mid-cycle and checks that PC_out holds until the edge. It then
    // checks the value that PC_out takes just after the edge.
    task automatic applyStimulus(input string tag, input logic r, input logic [XLEN-1:0] pc,
                                 input logic [XLEN-1:0] expected);
        @(negedge clk);
        reset = r;
        PC_in = pc;
        #1;
        checkOutput({tag, "_hold"}, PC_out, prevExpected);
        @(posedge clk);
        #1;
        checkOutput(tag, PC_out, expected);
        prevExpected = expected;
    endtask

    initial begin
        checkCount = 0;
        passCount  = 0;
        reset      = 1'b1;
        PC_in      = 32'h0000_0000;

        @(posedge clk);
        #1;
        checkOutput("reset_init", PC_out, 32'h0000_0000);
        prevExpected = 32'h0000_0000;

        applyStimulus("seq_4", 1'b0, 32'h0000_0004, 32'h0000_0004);
        applyStimulus("seq_8", 1'b0, 32'h0000_0008, 32'h0000_0008);
        applyStimulus("seq_c", 1'b0, 32'h0000_000C, 32'h0000_000C);

        applyStimulus("mid_reset", 1'b1, 32'h0000_000C, 32'h0000_0000);
        applyStimulus("post_reset", 1'b0, 32'h0000_000C, 32'h0000_000C);

        applyStimulus("seq_10", 1'b0, 32'h0000_0010, 32'h0000_0010);
        applyStimulus("seq_14", 1'b0, 32'h0000_0014, 32'h0000_0014);

        // A reset pulse that is low again by the edge must not clear the PC.
        @(negedge clk);
        PC_in = 32'h0000_0018;
        #1 reset = 1'b1;
        #1;
        checkOutput("glitch_hold", PC_out, 32'h0000_0014);
        #1 reset = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("glitch_load", PC_out, 32'h0000_0018);
        prevExpected = 32'h0000_0018;

        applyStimulus("top_addr", 1'b0, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
        applyStimulus("low_bits", 1'b0, 32'h0000_0003, 32'h0000_0003);
        applyStimulus("pattern_a5", 1'b0, 32'hA5A5_5A5A, 32'hA5A5_5A5A);
        applyStimulus("reset_again", 1'b1, 32'h1234_5678, 32'h0000_0000);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule : tb_program_counter
